rot_sched: RTL and testbench
============================

Name: rot_sched

Overview:
- Time-multiplexes the shared multi-h phase rotator across up to 32 trellis branches per symbol.
- On each symbol strobe it latches one I/Q sample, then issues one rotation per clock, one per branch, with the branch angle taken from a two-bank, h-indexed angle table.
- Tracks the rotator pipeline so that returned branch results are tagged valid. Pulses done when the last branch result arrives.
- Sits between the resampler/symbol-timing output and the rotator, upstream of the trellis branch-metric unit.

Parameters:
- MAX_BR, 32: number of angle-table entries per bank; maximum branch count.
- ROT_LAT, 5: clocks from the rotator's sel input to its selOut (rotator pipeline depth).

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- symEn  in  1  symbol strobe; single-cycle pulse
- sym2xEn  in  1  half-symbol strobe; forwarded to the rotator
- i  in  18  input I sample, signed
- q  in  18  input Q sample, signed
- numBr  in  6  branches per symbol, 1..32; 0 is treated as 1
- hSync  in  1  forces the next symbol to use bank 0
- cfgWe  in  1  angle-table write enable
- cfgBank  in  1  table bank to write
- cfgAddr  in  5  table entry (branch index) to write
- cfgAngle  in  3  angle code to write
- rotI  out  18  I sample to the rotator
- rotQ  out  18  Q sample to the rotator
- rotAngle  out  3  angle code to the rotator
- rotSel  out  5  branch tag to the rotator
- rotSymEn  out  1  symbol strobe to the rotator
- rotSym2xEn  out  1  half-symbol strobe to the rotator
- rotSelOut  in  5  branch tag returned from the rotator
- brValid  out  1  rotator output this cycle belongs to the current symbol
- brSel  out  5  branch index of the valid rotator output
- done  out  1  one-cycle pulse after the last branch result returns
- busy  out  1  high whenever state is not IDLE
- overrun  out  1  sticky; set when symEn arrives while busy

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - State goes to IDLE; branch counter, bank, and valid pipe clear.
  - All outputs are 0, including overrun.
  - The angle table is NOT cleared.
- Reset asserted mid-symbol aborts the symbol; no done pulse is issued.
- State machine:
  - IDLE, then ISSUE on symEn:
    - Latch i and q into rotI/rotQ.
    - Latch numBr as N (0 becomes 1).
    - Set cnt=0.
    - Bank = 0 if hSync is high, else the bank opposite the last one used. The first symbol after reset uses bank 0.
  - ISSUE, one cycle per branch:
    - rotSel=cnt; rotAngle=table[bank][cnt].
    - rotSymEn=1 only when cnt=0.
    - Push 1 into the valid pipe.
    - When cnt=N-1, go to DRAIN; otherwise cnt++.
  - DRAIN: wait until the valid pipe is empty, then go to IDLE.
  - rotAngle=0 whenever the block is not in ISSUE.
- Latency:
  - First issue occurs on the cycle after symEn.
  - A branch issued at cycle t appears at brValid/brSel at t+ROT_LAT.
  - done pulses in the same cycle as the last brValid. The block returns to IDLE on the next cycle.
  - Total busy time is N+ROT_LAT clocks.
- Valid pipe:
  - ROT_LAT-deep shift register, 1 bit per stage.
  - brValid = last stage; brSel = rotSelOut.
  - A mismatch between brSel and the expected return counter is a simulation assertion only, with no hardware effect.
- sym2xEn passes to rotSym2xEn with 1 clock delay so it stays aligned with rotSymEn.
- symEn while busy: the symbol is dropped, overrun is set sticky (cleared only by reset), and the bank does not toggle.
- symEn in the same cycle the block returns to IDLE: this is overrun (busy is still high).
- Config writes:
  - Writes are accepted in any state and take effect one clock later.
  - A write to the entry being read in that same cycle returns the old value.
- The angle table holds 2 x MAX_BR x 3 bits of distributed registers; the read is combinational by address.

Decomposition:
- Shared package constants: ROT_LAT_DEFAULT=5, MAX_BR_DEFAULT=32, ANGLE_W=3, SEL_W=5, SAMPLE_W=18.
- State encoding (IDLE/ISSUE/DRAIN) also goes in the package.
- One sub-module, rot_angle_tbl: two-bank register file with one write port and one combinational read port.

Test Plan:
1. Reset and idle: hold reset_n=0 for 4 clocks with symEn toggling -> all outputs 0, busy=0, no rotSymEn.
2. Basic symbol:
   - Stimulus: table bank0[k]=k mod 5, numBr=8, symEn with i=0x10000, q=0.
   - Expected: rotSel 0..7 on cycles 1..8, rotAngle 0,1,2,3,4,0,1,2, rotSymEn only on cycle 1.
   - Expected: brValid cycles 6..13, done at cycle 13, busy low at cycle 14.
3. Bank alternation:
   - Stimulus: bank1 all 7, bank0 all 1, numBr=4, three symbols 20 clocks apart.
   - Expected: angles 1,7,1. With hSync on the third symbol -> angles 1,7,1 with bank 0 forced.
4. Overrun: numBr=32, second symEn 10 clocks after the first -> overrun=1 and stays 1; the first symbol completes with 32 brValid and done. The dropped symbol issues nothing.
5. Boundaries:
   - numBr=0 -> exactly one issue (sel 0) and done at cycle 1+ROT_LAT.
   - numBr=32 -> sel 31 issued and done at cycle 37.
6. Reset mid-ISSUE: reset_n low at cnt=3 -> next cycle all outputs 0 and no done; a fresh symEn then behaves as in scenario 2 using bank 0.

Source files
------------

// File: rtl/rot_sched_pkg.sv
// Shared constants, state encoding and sample payload for the branch-rotation scheduler.
package rot_sched_pkg;

  localparam int unsigned ROT_LAT_DEFAULT = 5;
  localparam int unsigned MAX_BR_DEFAULT  = 32;
  localparam int unsigned ANGLE_W         = 3;
  localparam int unsigned SEL_W           = 5;
  localparam int unsigned SAMPLE_W        = 18;
  localparam int unsigned NUMBR_W         = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic signed [SAMPLE_W-1:0] i;
    logic signed [SAMPLE_W-1:0] q;
  } iq_t;

  // Branch count as used by the issue loop: 0 means 1, anything above the table depth saturates.
  function automatic logic [NUMBR_W-1:0] clamp_br(input logic [NUMBR_W-1:0] n,
                                                  input int unsigned max_br);
    if (n == '0) begin
      return NUMBR_W'(1);
    end else if (n > NUMBR_W'(max_br)) begin
      return NUMBR_W'(max_br);
    end
    return n;
  endfunction

endpackage

// File: rtl/rot_angle_tbl.sv
// Two-bank branch angle table: one write port, one combinational read port, not reset.
module rot_angle_tbl
  import rot_sched_pkg::*;
#(
  parameter int unsigned MAX_BR = MAX_BR_DEFAULT
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic               wr_bank,
  input  logic [SEL_W-1:0]   wr_addr,
  input  logic [ANGLE_W-1:0] wr_angle,
  input  logic               rd_bank,
  input  logic [SEL_W-1:0]   rd_addr,
  output logic [ANGLE_W-1:0] rd_angle_c
);

  logic [ANGLE_W-1:0] mem_q [2][MAX_BR];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_bank][wr_addr] <= wr_angle;
    end
  end

  assign rd_angle_c = mem_q[rd_bank][rd_addr];

endmodule

// File: rtl/rot_sched.sv
// Issues one rotator operation per trellis branch per symbol and tags the returning
// rotator results as valid, pulsing done alongside the last one.
module rot_sched
  import rot_sched_pkg::*;
#(
  parameter int unsigned MAX_BR  = MAX_BR_DEFAULT,
  parameter int unsigned ROT_LAT = ROT_LAT_DEFAULT
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                symEn,
  input  logic                sym2xEn,
  input  logic [SAMPLE_W-1:0] i,
  input  logic [SAMPLE_W-1:0] q,
  input  logic [NUMBR_W-1:0]  numBr,
  input  logic                hSync,
  input  logic                cfgWe,
  input  logic                cfgBank,
  input  logic [SEL_W-1:0]    cfgAddr,
  input  logic [ANGLE_W-1:0]  cfgAngle,
  output logic [SAMPLE_W-1:0] rotI,
  output logic [SAMPLE_W-1:0] rotQ,
  output logic [ANGLE_W-1:0]  rotAngle,
  output logic [SEL_W-1:0]    rotSel,
  output logic                rotSymEn,
  output logic                rotSym2xEn,
  input  logic [SEL_W-1:0]    rotSelOut,
  output logic                brValid,
  output logic [SEL_W-1:0]    brSel,
  output logic                done,
  output logic                busy,
  output logic                overrun
);

  localparam logic [ROT_LAT-1:0] VP_LAST = {1'b1, {(ROT_LAT-1){1'b0}}};

  state_e               state_q, state_d;
  logic [SEL_W-1:0]     cnt_q, cnt_d;
  logic [NUMBR_W-1:0]   n_q, n_d;
  logic                 bank_q, bank_d;
  logic                 next_bank_q, next_bank_d;
  logic [ROT_LAT-1:0]   vp_q, vp_d;
  iq_t                  iq_q, iq_d;
  logic [ANGLE_W-1:0]   angle_q, angle_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic                 sym_en_q, sym_en_d;
  logic                 sym2x_q, sym2x_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 overrun_q, overrun_d;
  logic [ANGLE_W-1:0]   tbl_angle_c;

  rot_angle_tbl #(.MAX_BR(MAX_BR)) u_tbl (
    .clk        (clk),
    .wr_en      (cfgWe),
    .wr_bank    (cfgBank),
    .wr_addr    (cfgAddr),
    .wr_angle   (cfgAngle),
    .rd_bank    (bank_d),
    .rd_addr    (cnt_d),
    .rd_angle_c (tbl_angle_c)
  );

  // Next-state and registered-output values; outputs follow the state being entered.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    bank_d      = bank_q;
    next_bank_d = next_bank_q;
    iq_d        = iq_q;
    overrun_d   = overrun_q;
    vp_d        = {vp_q[ROT_LAT-2:0], (state_q == ST_ISSUE)};

    case (state_q)
      ST_IDLE: begin
        if (symEn) begin
          state_d     = ST_ISSUE;
          cnt_d       = '0;
          n_d         = clamp_br(numBr, MAX_BR);
          bank_d      = hSync ? 1'b0 : next_bank_q;
          next_bank_d = hSync ? 1'b1 : ~next_bank_q;
          iq_d.i      = i;
          iq_d.q      = q;
        end
      end
      ST_ISSUE: begin
        if (NUMBR_W'(cnt_q) == n_q - NUMBR_W'(1)) begin
          state_d = ST_DRAIN;
        end else begin
          cnt_d = cnt_q + SEL_W'(1);
        end
      end
      ST_DRAIN: begin
        if (vp_d == '0) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A symbol strobe that arrives while busy is dropped and flagged.
    if (symEn && (state_q != ST_IDLE)) begin
      overrun_d = 1'b1;
    end

    sel_d    = (state_d == ST_ISSUE) ? cnt_d : '0;
    sym_en_d = (state_q == ST_IDLE) && (state_d == ST_ISSUE);
    sym2x_d  = sym2xEn;
    done_d   = (state_q == ST_DRAIN) && (vp_d == VP_LAST);
    busy_d   = (state_d != ST_IDLE);
  end

  always_comb begin
    angle_d = (state_d == ST_ISSUE) ? tbl_angle_c : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      n_q         <= '0;
      bank_q      <= 1'b0;
      next_bank_q <= 1'b0;
      vp_q        <= '0;
      iq_q        <= '0;
      angle_q     <= '0;
      sel_q       <= '0;
      sym_en_q    <= 1'b0;
      sym2x_q     <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      bank_q      <= bank_d;
      next_bank_q <= next_bank_d;
      vp_q        <= vp_d;
      iq_q        <= iq_d;
      angle_q     <= angle_d;
      sel_q       <= sel_d;
      sym_en_q    <= sym_en_d;
      sym2x_q     <= sym2x_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rotI       = iq_q.i;
  assign rotQ       = iq_q.q;
  assign rotAngle   = angle_q;
  assign rotSel     = sel_q;
  assign rotSymEn   = sym_en_q;
  assign rotSym2xEn = sym2x_q;
  assign brValid    = vp_q[ROT_LAT-1];
  assign brSel      = vp_q[ROT_LAT-1] ? rotSelOut : '0;
  assign done       = done_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

`ifndef SYNTHESIS
  // Returned tags must come back in issue order; checked in simulation only.
  logic [SEL_W-1:0] ret_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ret_cnt_q <= '0;
    end else if (sym_en_d) begin
      ret_cnt_q <= '0;
    end else if (vp_q[ROT_LAT-1]) begin
      ret_cnt_q <= ret_cnt_q + SEL_W'(1);
    end
    if (reset_n && vp_q[ROT_LAT-1]) begin
      assert (rotSelOut == ret_cnt_q)
        else $error("rot_sched: returned tag %0d, expected %0d", rotSelOut, ret_cnt_q);
    end
  end
`endif

endmodule

// File: tb/tb_rot_sched.sv
// Directed bench for rot_sched: symbol vectors from a table plus overrun and mid-symbol reset sequences.
module tb_rot_sched;

  localparam int ROT_LAT = 5;
  localparam int LOGN    = 44;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        symEn, sym2xEn, hSync, cfgWe, cfgBank;
  logic [17:0] i, q;
  logic [5:0]  numBr;
  logic [4:0]  cfgAddr;
  logic [2:0]  cfgAngle;
  logic [17:0] rotI, rotQ;
  logic [2:0]  rotAngle;
  logic [4:0]  rotSel, rotSelOut, brSel;
  logic        rotSymEn, rotSym2xEn, brValid, done, busy, overrun;

  always #5 clk = ~clk;

  rot_sched dut (
    .clk(clk), .reset_n(reset_n), .symEn(symEn), .sym2xEn(sym2xEn), .i(i), .q(q),
    .numBr(numBr), .hSync(hSync), .cfgWe(cfgWe), .cfgBank(cfgBank), .cfgAddr(cfgAddr),
    .cfgAngle(cfgAngle), .rotI(rotI), .rotQ(rotQ), .rotAngle(rotAngle), .rotSel(rotSel),
    .rotSymEn(rotSymEn), .rotSym2xEn(rotSym2xEn), .rotSelOut(rotSelOut), .brValid(brValid),
    .brSel(brSel), .done(done), .busy(busy), .overrun(overrun)
  );

  // Rotator stand-in: returns each tag ROT_LAT clocks after it was issued.
  logic [4:0] sel_pipe [ROT_LAT];
  always @(posedge clk) begin
    sel_pipe[0] <= rotSel;
    for (int k = 1; k < ROT_LAT; k++) sel_pipe[k] <= sel_pipe[k-1];
  end
  assign rotSelOut = sel_pipe[ROT_LAT-1];

  typedef struct {
    int          num_br;
    bit          hs;
    logic [17:0] iv;
    logic [17:0] qv;
    bit          bank;
    int          done_cyc;
    int          second_at;
    int          rst_at;
    bit          exp_ovr;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [2:0]  tbl_m [2][32];
  logic [63:0] l_all [LOGN];
  logic [4:0]  l_sel [LOGN];
  logic [2:0]  l_ang [LOGN];
  logic [4:0]  l_bsel [LOGN];
  logic [17:0] l_i [LOGN];
  logic [17:0] l_q [LOGN];
  logic        l_syn [LOGN];
  logic        l_s2x [LOGN];
  logic        l_bv [LOGN];
  logic        l_done [LOGN];
  logic        l_busy [LOGN];
  logic        l_ovr [LOGN];
  vec_t        vecs [8];
  vec_t        v;

  function automatic logic [63:0] outs_now();
    return 64'({rotI, rotQ, rotAngle, rotSel, rotSymEn, rotSym2xEn, brValid, brSel, done, busy, overrun});
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic cfg_write(input bit bank, input int addr, input logic [2:0] ang);
    cfgWe = 1'b1; cfgBank = bank; cfgAddr = 5'(addr); cfgAngle = ang;
    tbl_m[bank][addr] = ang;
    @(posedge clk); #1;
    cfgWe = 1'b0;
  endtask

  // Cycle 0 carries symEn; every cycle's outputs are logged at the falling edge.
  task automatic run_symbol(input vec_t vv);
    for (int c = 0; c < LOGN; c++) begin
      symEn   = (c == 0) || (c == vv.second_at);
      sym2xEn = (c == 0) || (c == 3);
      reset_n = (c != vv.rst_at);
      numBr   = 6'(vv.num_br);
      hSync   = vv.hs;
      i       = vv.iv;
      q       = vv.qv;
      @(negedge clk);
      l_all[c] = outs_now();
      l_sel[c] = rotSel;  l_ang[c] = rotAngle; l_syn[c] = rotSymEn; l_s2x[c] = rotSym2xEn;
      l_bv[c]  = brValid; l_bsel[c] = brSel;   l_done[c] = done;    l_busy[c] = busy;
      l_ovr[c] = overrun; l_i[c] = rotI;       l_q[c] = rotQ;
      @(posedge clk); #1;
    end
    symEn = 1'b0; sym2xEn = 1'b0; reset_n = 1'b1; hSync = 1'b0;
  endtask

  task automatic check_symbol(input int vi, input vec_t vv);
    int n, bv_cnt, done_cnt, done_at, se_cnt;
    n = (vv.num_br == 0) ? 1 : vv.num_br;
    bv_cnt = 0; done_cnt = 0; done_at = -1; se_cnt = 0;
    for (int k = 0; k < n; k++) begin
      chk($sformatf("v%0d_sel%0d", vi, k), 64'(l_sel[k+1]), 64'(k));
      chk($sformatf("v%0d_ang%0d", vi, k), 64'(l_ang[k+1]), 64'(tbl_m[vv.bank][k]));
      chk($sformatf("v%0d_symen%0d", vi, k), 64'(l_syn[k+1]), 64'(k == 0));
    end
    chk($sformatf("v%0d_ang_after", vi), 64'(l_ang[n+1]), 64'd0);
    for (int c = 0; c < LOGN; c++) begin
      bv_cnt += int'(l_bv[c]);
      se_cnt += int'(l_syn[c]);
      if (l_done[c]) begin done_cnt++; done_at = c; end
    end
    chk($sformatf("v%0d_bv_count", vi), 64'(bv_cnt), 64'(n));
    chk($sformatf("v%0d_symen_count", vi), 64'(se_cnt), 64'd1);
    chk($sformatf("v%0d_done_count", vi), 64'(done_cnt), 64'd1);
    chk($sformatf("v%0d_done_cyc", vi), 64'(done_at), 64'(vv.done_cyc));
    for (int j = 0; j < n; j++) begin
      chk($sformatf("v%0d_bv%0d", vi, j), 64'(l_bv[1+ROT_LAT+j]), 64'd1);
      chk($sformatf("v%0d_bsel%0d", vi, j), 64'(l_bsel[1+ROT_LAT+j]), 64'(j));
    end
    chk($sformatf("v%0d_busy0", vi), 64'(l_busy[0]), 64'd0);
    chk($sformatf("v%0d_busy1", vi), 64'(l_busy[1]), 64'd1);
    chk($sformatf("v%0d_busy_done", vi), 64'(l_busy[vv.done_cyc]), 64'd1);
    chk($sformatf("v%0d_busy_after", vi), 64'(l_busy[vv.done_cyc+1]), 64'd0);
    chk($sformatf("v%0d_rotI", vi), 64'(l_i[1]), 64'(vv.iv));
    chk($sformatf("v%0d_rotQ", vi), 64'(l_q[1]), 64'(vv.qv));
    chk($sformatf("v%0d_s2x1", vi), 64'(l_s2x[1]), 64'd1);
    chk($sformatf("v%0d_s2x2", vi), 64'(l_s2x[2]), 64'd0);
    chk($sformatf("v%0d_s2x4", vi), 64'(l_s2x[4]), 64'd1);
    chk($sformatf("v%0d_ovr", vi), 64'(l_ovr[LOGN-1]), 64'(vv.exp_ovr));
  endtask

  initial begin
    int bv_cnt, done_cnt;
    reset_n = 1'b0; symEn = 1'b0; sym2xEn = 1'b0; hSync = 1'b0;
    cfgWe = 1'b0; cfgBank = 1'b0; cfgAddr = '0; cfgAngle = '0;
    i = '0; q = '0; numBr = 6'd1;
    @(posedge clk); #1;

    // Reset held with symEn toggling: everything stays quiet.
    for (int c = 0; c < 4; c++) begin
      symEn = (c % 2 == 0);
      @(negedge clk);
      chk($sformatf("reset_outs%0d", c), outs_now(), 64'd0);
      @(posedge clk); #1;
    end
    symEn = 1'b0; reset_n = 1'b1;

    for (int k = 0; k < 32; k++) begin
      cfg_write(1'b0, k, 3'(k % 5));
      cfg_write(1'b1, k, 3'd7);
    end

    //          nb  hs    i           q           bank  done 2nd rst ovr
    vecs[0] = '{ 8, 1'b0, 18'h10000, 18'h00000, 1'b0, 13, -1, -1, 1'b0};
    vecs[1] = '{ 4, 1'b0, 18'h3FFFF, 18'h20000, 1'b1,  9, -1, -1, 1'b0};
    vecs[2] = '{ 4, 1'b0, 18'h00123, 18'h3FF00, 1'b0,  9, -1, -1, 1'b0};
    vecs[3] = '{ 4, 1'b1, 18'h1FFFF, 18'h00001, 1'b0,  9, -1, -1, 1'b0};
    vecs[4] = '{ 4, 1'b0, 18'h2AAAA, 18'h15555, 1'b1,  9, -1, -1, 1'b0};
    vecs[5] = '{ 1, 1'b0, 18'h00010, 18'h00020, 1'b0,  6, -1, -1, 1'b0};
    vecs[6] = '{ 0, 1'b0, 18'h30000, 18'h0F0F0, 1'b1,  6, -1, -1, 1'b0};
    vecs[7] = '{32, 1'b0, 18'h00777, 18'h3C3C3, 1'b0, 37, -1, -1, 1'b0};

    for (int vi = 0; vi < 8; vi++) begin
      run_symbol(vecs[vi]);
      check_symbol(vi, vecs[vi]);
    end

    // Second symEn ten clocks in: dropped, flagged, bank left alone.
    v = '{32, 1'b0, 18'h01234, 18'h04321, 1'b1, 37, 10, -1, 1'b1};
    run_symbol(v);
    check_symbol(8, v);
    chk("ovr_before_drop", 64'(l_ovr[10]), 64'd0);
    chk("ovr_after_drop", 64'(l_ovr[11]), 64'd1);

    v = '{4, 1'b0, 18'h00055, 18'h000AA, 1'b0, 9, -1, -1, 1'b1};
    run_symbol(v);
    check_symbol(9, v);

    // Reset while cnt=3 aborts the symbol without a done pulse.
    v = '{8, 1'b0, 18'h10000, 18'h00000, 1'b1, 13, -1, 4, 1'b0};
    run_symbol(v);
    chk("abort_sel_at_rst", 64'(l_sel[4]), 64'd3);
    chk("abort_outs_zero", l_all[5], 64'd0);
    bv_cnt = 0; done_cnt = 0;
    for (int c = 0; c < LOGN; c++) begin
      bv_cnt += int'(l_bv[c]);
      done_cnt += int'(l_done[c]);
    end
    chk("abort_bv_count", 64'(bv_cnt), 64'd0);
    chk("abort_done_count", 64'(done_cnt), 64'd0);
    chk("abort_idle", 64'(l_busy[LOGN-1]), 64'd0);

    v = '{8, 1'b0, 18'h10000, 18'h00000, 1'b0, 13, -1, -1, 1'b0};
    run_symbol(v);
    check_symbol(10, v);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
